// File: rtl/request_unit_pkg.sv
// Shared types for the request unit: FSM state encoding.
package request_unit_pkg;
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } rq_state_t;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; freeze blocks counting.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  input  logic         freeze,
  output logic [W-1:0] cnt
);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (inc && !freeze && (cnt != {W{1'b1}})) begin
      cnt <= cnt + ONE;
    end
  end
endmodule

// File: rtl/request_unit.sv
// Sequences icache/dcache requests for the single-cycle datapath, gates PC advance,
// and keeps saturating retired-instruction and stall counters.
module request_unit
  import request_unit_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic              halt,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [WORD_W-1:0] imemload,
  output logic [WORD_W-1:0] instr_out,
  output logic              imemREN,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic              pc_en,
  output logic              halt_out,
  output logic [CNT_W-1:0]  instr_count,
  output logic [CNT_W-1:0]  stall_count,
  output rq_state_t         state_dbg
);
  rq_state_t         state;
  logic [WORD_W-1:0] instr_q;
  logic              mem_op;
  logic              stall_inc;

  assign mem_op = dREN | dWEN;

  // Handshake: a strobe (imemREN/dmemREN/dmemWEN) is held until its hit arrives;
  // the cycle the hit is seen completes the access and retires the instruction.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= FETCH;
      dmemREN  <= 1'b0;
      dmemWEN  <= 1'b0;
      halt_out <= 1'b0;
      instr_q  <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (ihit) begin
            if (halt) begin
              state    <= HALTED;
              halt_out <= 1'b1;
            end else if (mem_op) begin
              instr_q <= imemload;
              dmemWEN <= dWEN;
              dmemREN <= dREN & ~dWEN;
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (dhit) begin
            dmemREN <= 1'b0;
            dmemWEN <= 1'b0;
            state   <= FETCH;
          end
        end
        HALTED: begin
          dmemREN  <= 1'b0;
          dmemWEN  <= 1'b0;
          halt_out <= 1'b1;
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign imemREN   = (state == FETCH) & iREN;
  assign instr_out = (state == DATA) ? instr_q : imemload;
  // Gated by nRST so an access aborted by reset can never advance the PC.
  assign pc_en     = nRST & (((state == FETCH) & ihit & ~halt & ~mem_op) |
                             ((state == DATA) & dhit));
  assign stall_inc = ((state == FETCH) & ~ihit) | ((state == DATA) & ~dhit);
  assign state_dbg = state;

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .CLK    (CLK),
    .nRST   (nRST),
    .inc    (pc_en),
    .freeze (state == HALTED),
    .cnt    (instr_count)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK    (CLK),
    .nRST   (nRST),
    .inc    (stall_inc),
    .freeze (state == HALTED),
    .cnt    (stall_count)
  );
endmodule
